// File: rtl/iopage_pkg.sv
// Shared constants for the I/O page: 13-bit register offsets, console TTY vectors/IPL,
// and the UART state encodings.
package iopage_pkg;

  localparam logic [12:0] ADDR_RCSR   = 13'o17560;
  localparam logic [12:0] ADDR_RBUF   = 13'o17562;
  localparam logic [12:0] ADDR_XCSR   = 13'o17564;
  localparam logic [12:0] ADDR_XBUF   = 13'o17566;
  localparam logic [12:0] ADDR_SWITCH = 13'o17570;
  localparam logic [12:0] ADDR_IDE    = 13'o17600;
  localparam logic [12:0] ADDR_PSW    = 13'o17776;

  localparam logic [7:0] VEC_RX  = 8'o060;
  localparam logic [7:0] VEC_TX  = 8'o064;
  localparam logic [7:0] IPL_TTY = 8'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Registers are word-addressed; address bit 0 only selects the byte lane.
  function automatic logic word_hit(input logic [12:0] addr, input logic [12:0] reg_addr);
    return addr[12:1] == reg_addr[12:1];
  endfunction

endpackage

// File: rtl/uart_8n1.sv
// 8N1 serial transmitter and receiver sharing one bit-period divider constant.
// Handshake: i_tx_start is honoured only in a cycle where o_tx_ready=1; o_rx_valid is a one-cycle pulse.
module uart_8n1
  import iopage_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_txd,
  input  logic       i_rxd,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic [1:0] o_tx_state,
  output logic [1:0] o_rx_state
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(BAUD_DIV / 2 - 1);

  tx_state_e     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_txd;
  logic          r_tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (i_tx_start) begin
            r_tx_state <= TX_START;
            r_tx_shift <= i_tx_data;
            r_tx_cnt   <= '0;
            r_txd      <= 1'b0;
            r_tx_ready <= 1'b0;
          end
        end
        TX_START: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_state <= TX_DATA;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= TX_STOP;
              r_txd      <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_ready <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  rx_state_e     r_rx_state;
  logic [1:0]    r_rx_sync;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          w_rxd;

  assign w_rxd = r_rx_sync[1];

  // Start edge is re-checked at half a bit so glitches shorter than that are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_sync  <= 2'b11;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], i_rxd};
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rxd) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == BIT_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= w_rxd ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (w_rxd) begin
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_rx_shift;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_txd      = r_txd;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;
  assign o_tx_state = r_tx_state;
  assign o_rx_state = r_rx_state;

endmodule

// File: rtl/io_page.sv
// PDP-11 style I/O page: PSW/switch registers, console TTY (DL11-like), IDE window
// and console interrupt arbitration. Bus reads and decode errors are combinational.
module io_page
  import iopage_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        iopage_rd,
  input  logic        iopage_wr,
  input  logic        iopage_byte_op,
  output logic        no_decode,
  output logic        interrupt,
  output logic [7:0]  interrupt_ipl,
  input  logic [7:0]  ack_ipl,
  output logic [7:0]  vector,
  inout  wire  [15:0] ide_data_bus,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da,
  input  logic [15:0] psw,
  output logic        psw_io_wr,
  input  logic [15:0] switches,
  output logic        rs232_tx,
  input  logic        rs232_rx,
  output logic        dma_req,
  input  logic        dma_ack,
  output logic [17:0] dma_addr,
  input  logic [15:0] dma_data_in,
  output logic [15:0] dma_data_out,
  output logic        dma_rd,
  output logic        dma_wr
);

  logic [12:0] w_addr;
  logic w_strobe, w_decoded, w_lo_sel, w_ide_act;
  logic w_sel_psw, w_sel_sw, w_sel_rcsr, w_sel_rbuf, w_sel_xcsr, w_sel_xbuf, w_sel_ide;
  logic [7:0] w_wbyte;
  logic w_wr_rcsr, w_wr_xcsr, w_tx_start, w_rbuf_rd, w_rx_irq, w_tx_set, w_tx_ack;
  logic w_tx_ready, w_rx_valid;
  logic [7:0] w_rx_data;
  logic [1:0] w_tx_state, w_rx_state;
  logic r_done, r_rx_ie, r_tx_ie, r_tx_pend, r_ready_q;
  logic [7:0] r_rbuf;

  assign w_addr     = address[12:0];
  assign w_strobe   = iopage_rd | iopage_wr;
  assign w_sel_psw  = word_hit(w_addr, ADDR_PSW);
  assign w_sel_sw   = word_hit(w_addr, ADDR_SWITCH);
  assign w_sel_rcsr = word_hit(w_addr, ADDR_RCSR);
  assign w_sel_rbuf = word_hit(w_addr, ADDR_RBUF);
  assign w_sel_xcsr = word_hit(w_addr, ADDR_XCSR);
  assign w_sel_xbuf = word_hit(w_addr, ADDR_XBUF);
  assign w_sel_ide  = (w_addr[12:4] == ADDR_IDE[12:4]);
  assign w_decoded  = w_sel_psw | w_sel_sw | w_sel_rcsr | w_sel_rbuf |
                      w_sel_xcsr | w_sel_xbuf | w_sel_ide;
  assign no_decode  = w_strobe & ~w_decoded;
  assign psw_io_wr  = iopage_wr & w_sel_psw;

  // An odd-address byte write carries its byte on the high lane; CSR bits live in the low byte.
  assign w_lo_sel   = ~iopage_byte_op | ~w_addr[0];
  assign w_wbyte    = (iopage_byte_op & w_addr[0]) ? data_in[15:8] : data_in[7:0];
  assign w_wr_rcsr  = iopage_wr & w_sel_rcsr & w_lo_sel;
  assign w_wr_xcsr  = iopage_wr & w_sel_xcsr & w_lo_sel;
  assign w_tx_start = iopage_wr & w_sel_xbuf & w_tx_ready;
  assign w_rbuf_rd  = iopage_rd & w_sel_rbuf;

  assign w_rx_irq = r_done & r_rx_ie;
  assign w_tx_set = (w_tx_ready & ~r_ready_q & r_tx_ie) |
                    (w_wr_xcsr & w_wbyte[6] & ~r_tx_ie & w_tx_ready);
  assign w_tx_ack = (ack_ipl == IPL_TTY) & r_tx_pend & ~w_rx_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done    <= 1'b0;
      r_rx_ie   <= 1'b0;
      r_tx_ie   <= 1'b0;
      r_rbuf    <= '0;
      r_tx_pend <= 1'b0;
      r_ready_q <= 1'b1;
    end else begin
      r_ready_q <= w_tx_ready;
      if (w_rx_valid) begin
        r_done <= 1'b1;
        r_rbuf <= w_rx_data;
      end else if (w_rbuf_rd) begin
        r_done <= 1'b0;
      end
      if (w_wr_rcsr) r_rx_ie <= w_wbyte[6];
      if (w_wr_xcsr) r_tx_ie <= w_wbyte[6];
      if (w_tx_set)      r_tx_pend <= 1'b1;
      else if (w_tx_ack) r_tx_pend <= 1'b0;
    end
  end

  assign interrupt     = w_rx_irq | r_tx_pend;
  assign interrupt_ipl = interrupt ? IPL_TTY : 8'd0;
  assign vector        = w_rx_irq ? VEC_RX : (r_tx_pend ? VEC_TX : 8'd0);

  assign w_ide_act    = w_sel_ide & w_strobe;
  assign ide_cs       = w_ide_act ? 2'b10 : 2'b11;
  assign ide_da       = w_ide_act ? w_addr[3:1] : 3'd0;
  assign ide_dior     = ~(w_sel_ide & iopage_rd);
  assign ide_diow     = ~(w_sel_ide & iopage_wr);
  assign ide_data_bus = (w_sel_ide & iopage_wr) ? data_in : 16'hzzzz;

  always_comb begin
    data_out = '0;
    if (iopage_rd) begin
      if (w_sel_psw)       data_out = psw;
      else if (w_sel_sw)   data_out = switches;
      else if (w_sel_rcsr) data_out = {8'd0, r_done, r_rx_ie, 6'd0};
      else if (w_sel_rbuf) data_out = {8'd0, r_rbuf};
      else if (w_sel_xcsr) data_out = {8'd0, w_tx_ready, r_tx_ie, 6'd0};
      else if (w_sel_ide)  data_out = ide_data_bus;
    end
  end

  assign dma_req      = 1'b0;
  assign dma_rd       = 1'b0;
  assign dma_wr       = 1'b0;
  assign dma_addr     = '0;
  assign dma_data_out = '0;

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, dma_ack, dma_data_in, address[21:13], w_tx_state, w_rx_state};

  uart_8n1 #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (reset),
    .i_tx_start (w_tx_start),
    .i_tx_data  (w_wbyte),
    .o_tx_ready (w_tx_ready),
    .o_txd      (rs232_tx),
    .i_rxd      (rs232_rx),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_data),
    .o_tx_state (w_tx_state),
    .o_rx_state (w_rx_state)
  );

endmodule

// File: tb/tb_io_page.sv
// Self-checking bench for io_page: register decode, console UART framing,
// interrupt arbitration and the IDE window.
module tb_io_page;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] address;
  logic [15:0] data_in, data_out;
  logic        iopage_rd, iopage_wr, iopage_byte_op;
  logic        no_decode, interrupt;
  logic [7:0]  interrupt_ipl, ack_ipl, vector;
  wire  [15:0] ide_data_bus;
  logic        ide_dior, ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;
  logic [15:0] psw, switches;
  logic        psw_io_wr, rs232_tx, rs232_rx;
  logic        dma_req, dma_ack, dma_rd, dma_wr;
  logic [17:0] dma_addr;
  logic [15:0] dma_data_in, dma_data_out;

  logic        tb_ide_drv;
  logic [15:0] tb_ide_val;
  assign ide_data_bus = tb_ide_drv ? tb_ide_val : 16'hzzzz;

  logic [15:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  io_page #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .reset(rst_n), .address(address), .data_in(data_in), .data_out(data_out),
    .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
    .no_decode(no_decode), .interrupt(interrupt), .interrupt_ipl(interrupt_ipl),
    .ack_ipl(ack_ipl), .vector(vector), .ide_data_bus(ide_data_bus), .ide_dior(ide_dior),
    .ide_diow(ide_diow), .ide_cs(ide_cs), .ide_da(ide_da), .psw(psw), .psw_io_wr(psw_io_wr),
    .switches(switches), .rs232_tx(rs232_tx), .rs232_rx(rs232_rx), .dma_req(dma_req),
    .dma_ack(dma_ack), .dma_addr(dma_addr), .dma_data_in(dma_data_in),
    .dma_data_out(dma_data_out), .dma_rd(dma_rd), .dma_wr(dma_wr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  // Driver tasks
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic bop);
    @(negedge clk);
    address = {6'h3f, a}; data_in = d; iopage_byte_op = bop; iopage_wr = 1'b1;
    @(negedge clk);
    iopage_wr = 1'b0; iopage_byte_op = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic nd);
    @(negedge clk);
    address = {6'h3f, a}; iopage_rd = 1'b1;
    #1 d = data_out; nd = no_decode;
    @(negedge clk);
    iopage_rd = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rs232_rx = f[i];
      repeat (BAUD - 1) @(negedge clk);
    end
  endtask

  task automatic wait_irq();
    int c;
    c = 0;
    while (interrupt !== 1'b1 && c < 4 * BAUD) begin @(negedge clk); c++; end
    n_vec++;
    if (interrupt !== 1'b1) begin $display("FAIL irq_timeout: interrupt=%b want 1", interrupt); n_err++; end
  endtask

  // Test scenarios
  task automatic test_reset();
    logic [15:0] v; logic nd;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (rs232_tx !== 1'b1) begin $display("FAIL rst_tx: got %b want 1", rs232_tx); n_err++; end
    n_vec++; if ({interrupt, interrupt_ipl, vector} !== 17'd0) begin
      $display("FAIL rst_irq: got %b/%h/%h want 0/00/00", interrupt, interrupt_ipl, vector); n_err++; end
    n_vec++; if ({dma_req, dma_rd, dma_wr, dma_addr, dma_data_out} !== 37'd0) begin
      $display("FAIL rst_dma: got %b%b%b %h %h want all 0", dma_req, dma_rd, dma_wr, dma_addr, dma_data_out); n_err++; end
    n_vec++; if ({ide_cs, ide_dior, ide_diow, ide_da} !== 7'b1111000) begin
      $display("FAIL rst_ide: cs=%b dior=%b diow=%b da=%0d want 11 1 1 0", ide_cs, ide_dior, ide_diow, ide_da); n_err++; end
    @(negedge clk); rst_n = 1'b1;
    bus_read(16'o177560, v, nd);
    n_vec++; if (v !== 16'h0000) begin $display("FAIL rst_rcsr: got %h want 0000", v); n_err++; end
    bus_read(16'o177564, v, nd);
    n_vec++; if (v !== 16'h0080) begin $display("FAIL rst_xcsr: got %h want 0080", v); n_err++; end
    bus_read(16'o177562, v, nd);
    n_vec++; if (v !== 16'h0000) begin $display("FAIL rst_rbuf: got %h want 0000", v); n_err++; end
  endtask

  task automatic test_psw();
    logic [15:0] v; logic nd;
    psw = 16'o000340;
    bus_read(16'o177776, v, nd);
    n_vec++; if (v !== 16'o000340 || nd !== 1'b0) begin
      $display("FAIL psw_read: got %o nd=%b want 000340 nd=0", v, nd); n_err++; end
    @(negedge clk);
    address = {6'h3f, 16'o177776}; data_in = 16'o000017; iopage_wr = 1'b1;
    #1 n_vec++; if (psw_io_wr !== 1'b1) begin $display("FAIL psw_wr_strobe: got %b want 1", psw_io_wr); n_err++; end
    @(negedge clk); iopage_wr = 1'b0;
    #1 n_vec++; if (psw_io_wr !== 1'b0) begin $display("FAIL psw_wr_release: got %b want 0", psw_io_wr); n_err++; end
  endtask

  task automatic test_switches();
    logic [15:0] v; logic nd;
    switches = 16'o123456;
    bus_write(16'o177570, 16'o7777, 1'b0);
    bus_read(16'o177570, v, nd);
    n_vec++; if (v !== 16'o123456 || nd !== 1'b0) begin
      $display("FAIL sw_read: got %o nd=%b want 123456 nd=0", v, nd); n_err++; end
    bus_read(16'o177000, v, nd);
    n_vec++; if (v !== 16'h0000 || nd !== 1'b1) begin
      $display("FAIL nodecode_177000: got %h nd=%b want 0000 nd=1", v, nd); n_err++; end
    bus_read(16'o177620, v, nd);
    n_vec++; if (nd !== 1'b1) begin $display("FAIL nodecode_177620: nd=%b want 1", nd); n_err++; end
  endtask

  task automatic test_uart_tx();
    logic [15:0] v, e; logic nd; logic [7:0] b; int lows;
    b = 8'h41;
    exp_q.delete();
    exp_q.push_back(16'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back({15'd0, b[i]});
    exp_q.push_back(16'd1);
    bus_write(16'o177566, {8'h00, b}, 1'b0);
    bus_read(16'o177564, v, nd);
    n_vec++; if (v !== 16'h0000) begin $display("FAIL tx_busy_ready: got %h want 0000", v); n_err++; end
    bus_write(16'o177566, 16'h00FF, 1'b0);
    repeat (BAUD / 2 - 4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (rs232_tx !== e[0]) begin $display("FAIL tx_bit%0d: got %b want %b", i, rs232_tx, e[0]); n_err++; end
      if (i < 9) repeat (BAUD) @(negedge clk);
    end
    repeat (BAUD / 2 + 2) @(negedge clk);
    bus_read(16'o177564, v, nd);
    n_vec++; if (v !== 16'h0080) begin $display("FAIL tx_done_ready: got %h want 0080", v); n_err++; end
    lows = 0;
    repeat (2 * BAUD) begin @(negedge clk); if (rs232_tx !== 1'b1) lows++; end
    n_vec++; if (lows != 0) begin $display("FAIL tx_dropped_write: %0d low cycles want 0", lows); n_err++; end
  endtask

  task automatic test_uart_rx();
    logic [15:0] v, e; logic nd;
    bus_write(16'o177560, 16'h0040, 1'b0);
    n_vec++; if (interrupt !== 1'b0) begin $display("FAIL rx_idle_irq: got %b want 0", interrupt); n_err++; end
    exp_q.push_back(16'h005A);
    drive_rx(8'h5A);
    wait_irq();
    n_vec++; if (interrupt_ipl !== 8'd4 || vector !== 8'o060) begin
      $display("FAIL rx_irq: ipl=%0d vec=%o want 4/060", interrupt_ipl, vector); n_err++; end
    bus_read(16'o177560, v, nd);
    n_vec++; if (v !== 16'h00C0) begin $display("FAIL rx_rcsr_done: got %h want 00c0", v); n_err++; end
    bus_read(16'o177562, v, nd);
    e = exp_q.pop_front();
    n_vec++; if (v !== e) begin $display("FAIL rx_rbuf: got %h want %h", v, e); n_err++; end
    #1 n_vec++; if (interrupt !== 1'b0 || vector !== 8'd0) begin
      $display("FAIL rx_irq_clear: irq=%b vec=%o want 0/0", interrupt, vector); n_err++; end
  endtask

  task automatic test_rx_overwrite();
    logic [15:0] v, e; logic nd;
    exp_q.push_back(16'h003C); drive_rx(8'h3C);
    exp_q.push_back(16'h00A5); drive_rx(8'hA5);
    wait_irq();
    bus_read(16'o177562, v, nd);
    e = exp_q[$]; exp_q.delete();
    n_vec++; if (v !== e) begin $display("FAIL rx_overwrite: got %h want %h", v, e); n_err++; end
  endtask

  task automatic test_byte_ops();
    logic [15:0] v; logic nd;
    bus_write(16'o177560, 16'h0000, 1'b0);
    bus_write(16'o177561, 16'h0040, 1'b1);
    bus_read(16'o177560, v, nd);
    n_vec++; if (v !== 16'h0000) begin $display("FAIL byte_odd_ignored: got %h want 0000", v); n_err++; end
    bus_write(16'o177560, 16'h0040, 1'b1);
    bus_read(16'o177560, v, nd);
    n_vec++; if (v !== 16'h0040) begin $display("FAIL byte_even_set: got %h want 0040", v); n_err++; end
    bus_write(16'o177561, 16'h4000, 1'b1);
    bus_read(16'o177560, v, nd);
    n_vec++; if (v !== 16'h0040) begin $display("FAIL byte_odd_keep: got %h want 0040", v); n_err++; end
    bus_write(16'o177560, 16'h0000, 1'b0);
  endtask

  task automatic test_tx_irq();
    bus_write(16'o177564, 16'h0040, 1'b0);
    #1 n_vec++; if (interrupt !== 1'b1 || interrupt_ipl !== 8'd4 || vector !== 8'o064) begin
      $display("FAIL txirq_ie: irq=%b ipl=%0d vec=%o want 1/4/064", interrupt, interrupt_ipl, vector); n_err++; end
    @(negedge clk); ack_ipl = 8'd4;
    #1 n_vec++; if (interrupt !== 1'b1) begin $display("FAIL txirq_pre_ack: got %b want 1", interrupt); n_err++; end
    @(negedge clk); ack_ipl = 8'd0;
    #1 n_vec++; if ({interrupt, interrupt_ipl, vector} !== 17'd0) begin
      $display("FAIL txirq_ack: irq=%b ipl=%0d vec=%o want 0/0/0", interrupt, interrupt_ipl, vector); n_err++; end
  endtask

  task automatic test_priority();
    logic [15:0] v, e; logic nd;
    bus_write(16'o177560, 16'h0040, 1'b0);
    bus_write(16'o177566, 16'h0000, 1'b0);
    exp_q.push_back(16'h0077);
    drive_rx(8'h77);
    repeat (2 * BAUD) @(negedge clk);
    n_vec++; if (interrupt !== 1'b1 || vector !== 8'o060) begin
      $display("FAIL prio_rx_first: irq=%b vec=%o want 1/060", interrupt, vector); n_err++; end
    @(negedge clk); ack_ipl = 8'd4;
    @(negedge clk); ack_ipl = 8'd0;
    bus_read(16'o177562, v, nd);
    e = exp_q.pop_front();
    n_vec++; if (v !== e) begin $display("FAIL prio_rbuf: got %h want %h", v, e); n_err++; end
    #1 n_vec++; if (interrupt !== 1'b1 || vector !== 8'o064) begin
      $display("FAIL prio_tx_kept: irq=%b vec=%o want 1/064", interrupt, vector); n_err++; end
    @(negedge clk); ack_ipl = 8'd4;
    @(negedge clk); ack_ipl = 8'd0;
    #1 n_vec++; if (interrupt !== 1'b0) begin $display("FAIL prio_tx_ack: got %b want 0", interrupt); n_err++; end
    bus_write(16'o177560, 16'h0000, 1'b0);
    bus_write(16'o177564, 16'h0000, 1'b0);
  endtask

  task automatic test_ide();
    tb_ide_drv = 1'b0;
    @(negedge clk);
    address = {6'h3f, 16'o177602}; data_in = 16'h1234; iopage_wr = 1'b1;
    #1 n_vec++; if (ide_cs !== 2'b10 || ide_da !== 3'd1 || ide_diow !== 1'b0 || ide_dior !== 1'b1 || no_decode !== 1'b0) begin
      $display("FAIL ide_wr_ctl: cs=%b da=%0d diow=%b dior=%b nd=%b want 10 1 0 1 0", ide_cs, ide_da, ide_diow, ide_dior, no_decode); n_err++; end
    n_vec++; if (ide_data_bus !== 16'h1234) begin $display("FAIL ide_wr_bus: got %h want 1234", ide_data_bus); n_err++; end
    @(negedge clk);
    iopage_wr = 1'b0; data_in = 16'h5A5A; tb_ide_val = 16'hA5A5; tb_ide_drv = 1'b1;
    #1 n_vec++; if (ide_data_bus !== 16'hA5A5 || ide_cs !== 2'b11 || ide_da !== 3'd0 || ide_diow !== 1'b1) begin
      $display("FAIL ide_idle: bus=%h cs=%b da=%0d diow=%b want a5a5 11 0 1", ide_data_bus, ide_cs, ide_da, ide_diow); n_err++; end
    @(negedge clk);
    address = {6'h3f, 16'o177616}; tb_ide_val = 16'hBEEF; iopage_rd = 1'b1;
    #1 n_vec++; if (data_out !== 16'hBEEF || ide_dior !== 1'b0 || ide_da !== 3'd7 || ide_cs !== 2'b10) begin
      $display("FAIL ide_rd: data=%h dior=%b da=%0d cs=%b want beef 0 7 10", data_out, ide_dior, ide_da, ide_cs); n_err++; end
    @(negedge clk);
    iopage_rd = 1'b0; tb_ide_drv = 1'b0;
  endtask

  initial begin
    address = '0; data_in = '0; iopage_rd = 1'b0; iopage_wr = 1'b0; iopage_byte_op = 1'b0;
    ack_ipl = '0; psw = '0; switches = '0; rs232_rx = 1'b1; dma_ack = 1'b0; dma_data_in = '0;
    tb_ide_drv = 1'b0; tb_ide_val = '0;
    test_reset();
    test_psw();
    test_switches();
    test_uart_tx();
    test_uart_rx();
    test_rx_overwrite();
    test_byte_ops();
    test_tx_irq();
    test_priority();
    test_ide();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
